ex_stage: RTL

- Consumer end of the ID/EX pipeline register. Takes the ID/EX bundle, resolves RAW hazards through forwarding muxes, and executes the 3-bit ALU operation.
- Holds the EX/MEM pipeline register internally and drives its outputs to the MEM stage.
- Detects load-use hazards against the load it holds in EX/MEM. Asserts a one-cycle stall to the upstream IF/ID and ID/EX registers and inserts a bubble downstream.

---
 rtl/ex_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// EX stage: forwarding muxes, ALU, load-use stall FSM
// and the EX/MEM pipeline register feeding MEM.
module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [2:0]    alu_sig_in,
  input  logic          wb_in,
  input  logic          extend_for_mem_in,
  input  logic          wmem_in,
  input  logic          load_in,
  input  logic          b_is_reg_in,
  input  logic [DW-1:0] r1_in,
  input  logic [DW-1:0] r2_in,
  input  logic [DW-1:0] wd_mem_in,
  input  logic [RW-1:0] rd_in,
  input  logic [RW-1:0] rs_in,
  input  logic [RW-1:0] rt_in,
  input  logic          wb_wb_in,
  input  logic [RW-1:0] wb_rd_in,
  input  logic [DW-1:0] wb_data_in,
  output logic          stall_out,
  output logic [DW-1:0] alu_result_out,
  output logic [DW-1:0] wd_mem_out,
  output logic [RW-1:0] rd_out,
  output logic          wb_out,
  output logic          extend_for_mem_out,
  output logic          wmem_out,
  output logic          load_out
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]    r_state;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_wd;
  logic [RW-1:0] r_rd;
  logic          r_wb;
  logic          r_ext;
  logic          r_wmem;
  logic          r_load;

  logic          w_mem_ok;
  logic          w_wb_ok;
  logic          w_mem_a;
  logic          w_mem_b;
  logic          w_wb_a;
  logic          w_wb_b;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b_reg;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_st;
  logic [DW-1:0] w_res;
  logic          w_hit_rs;
  logic          w_hit_rt;
  logic          w_hazard;
  logic          w_stall;
  logic          w_bubble;

  // Loads in EX/MEM have no data yet, so they never feed the MEM path.
  assign w_mem_ok = r_wb & ~r_load & (r_rd != '0);
  assign w_wb_ok  = wb_wb_in & (wb_rd_in != '0);

  assign w_mem_a = w_mem_ok & (r_rd == rs_in);
  assign w_mem_b = w_mem_ok & (r_rd == rt_in);
  assign w_wb_a  = w_wb_ok & (wb_rd_in == rs_in);
  assign w_wb_b  = w_wb_ok & (wb_rd_in == rt_in);

  always_comb begin
    w_a = r1_in;
    if (w_mem_a)
      w_a = r_alu;
    else if (w_wb_a)
      w_a = wb_data_in;
  end

  always_comb begin
    w_b_reg = r2_in;
    if (w_mem_b)
      w_b_reg = r_alu;
    else if (w_wb_b)
      w_b_reg = wb_data_in;
  end

  always_comb begin
    w_st = wd_mem_in;
    if (w_mem_b)
      w_st = r_alu;
    else if (w_wb_b)
      w_st = wb_data_in;
  end

  assign w_b = b_is_reg_in ? w_b_reg : r2_in;

  always_comb begin
    w_res = '0;
    unique case (alu_sig_in)
      3'b000: w_res = w_a + w_b;
      3'b001: w_res = w_a - w_b;
      3'b010: w_res = w_a & w_b;
      3'b011: w_res = w_a | w_b;
      3'b100: w_res = w_a ^ w_b;
      3'b101: w_res = {{(DW-1){1'b0}},
                       $signed(w_a) < $signed(w_b)};
      3'b110: w_res = w_a << w_b[4:0];
      3'b111: w_res = w_a >> w_b[4:0];
      default: w_res = '0;
    endcase
  end

  assign w_hit_rs = (r_rd == rs_in);
  assign w_hit_rt = (r_rd == rt_in) & (b_is_reg_in | wmem_in);
  assign w_hazard = r_load & r_wb & (r_rd != '0)
                  & (w_hit_rs | w_hit_rt);

  // One stall suffices: next cycle the load sits in WB.
  assign w_stall  = rst_n & ~flush & (r_state == S_RUN) & w_hazard;
  assign w_bubble = flush | w_stall;
  assign stall_out = w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_alu   <= '0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_wb    <= 1'b0;
      r_ext   <= 1'b0;
      r_wmem  <= 1'b0;
      r_load  <= 1'b0;
    end else if (w_bubble) begin
      r_state <= w_stall ? S_STALL : S_RUN;
      r_alu   <= '0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_wb    <= 1'b0;
      r_ext   <= 1'b0;
      r_wmem  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= S_RUN;
      r_alu   <= w_res;
      r_wd    <= w_st;
      r_rd    <= rd_in;
      r_wb    <= wb_in;
      r_ext   <= extend_for_mem_in;
      r_wmem  <= wmem_in;
      r_load  <= load_in;
    end
  end

  assign alu_result_out     = r_alu;
  assign wd_mem_out         = r_wd;
  assign rd_out             = r_rd;
  assign wb_out             = r_wb;
  assign extend_for_mem_out = r_ext;
  assign wmem_out           = r_wmem;
  assign load_out           = r_load;

endmodule
